capture_sequencer: RTL

//  UART-command-driven sequencer for the acoustics ADC capture datapath; replaces the bring-up test controller.

---
 rtl/capture_pkg.sv | 53 +++++
 rtl/tx_byte_handshake.sv | 56 +++++
 rtl/capture_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding, host command bytes and byte-select
// encodings for the capture sequencer. Build macro CAPTURE_SEQ_HEADER_EN
// (used by capture_sequencer) enables the HDR0/HDR1 sync-byte states.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOG     = 3'd1,
        HDR0    = 3'd2,
        HDR1    = 3'd3,
        SEND_HI = 3'd4,
        SEND_LO = 3'd5,
        WAIT_TX = 3'd6,
        ADV     = 3'd7
    } state_t;

    localparam logic [7:0] CMD_START = 8'h53;  // 'S'
    localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'
    localparam logic [7:0] CMD_ABORT = 8'h58;  // 'X'

    localparam logic [1:0] SEL_LO   = 2'd0;
    localparam logic [1:0] SEL_HI   = 2'd1;
    localparam logic [1:0] SEL_HDR0 = 2'd2;
    localparam logic [1:0] SEL_HDR1 = 2'd3;

    // Bytes the datapath mux emits for SEL_HDR0 / SEL_HDR1.
    localparam logic [7:0] HDR_BYTE0 = 8'hA5;
    localparam logic [7:0] HDR_BYTE1 = 8'h5A;

    function automatic logic is_send_state(input state_t s);
        return (s == HDR0) || (s == HDR1) || (s == SEND_HI) || (s == SEND_LO);
    endfunction

    function automatic logic [1:0] sel_for(input state_t s);
        case (s)
            HDR0:    return SEL_HDR0;
            HDR1:    return SEL_HDR1;
            SEND_HI: return SEL_HI;
            default: return SEL_LO;
        endcase
    endfunction

    // State entered once the byte sent from state s has completed.
    function automatic state_t after_byte(input state_t s);
        case (s)
            HDR0:    return HDR1;
            HDR1:    return SEND_HI;
            SEND_HI: return SEND_LO;
            default: return ADV;
        endcase
    endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// tx_byte_handshake: turns a 'go' request into a single tx_send strobe and
// reports 'done' once the transmitter has gone busy (tx_ready low) and idle
// again. Standalone so other byte senders can reuse it.
module tx_byte_handshake (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic tx_ready,
    output logic tx_send,
    output logic done
);

    typedef enum logic [1:0] {
        HS_IDLE      = 2'd0,
        HS_WAIT_LOW  = 2'd1,
        HS_WAIT_HIGH = 2'd2
    } hs_state_t;

    hs_state_t state, state_nxt;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values, independent of process ordering.
        if (reset) state <= HS_IDLE;
        else       state <= state_nxt;
    end

    // Strobe tx_send only into an idle transmitter, then wait low->high.
    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        tx_send   = 1'b0;
        done      = 1'b0;
        case (state)
            HS_IDLE: begin
                if (go && tx_ready) begin
                    tx_send   = 1'b1;
                    state_nxt = HS_WAIT_LOW;
                end
            end
            HS_WAIT_LOW: begin
                if (!tx_ready) state_nxt = HS_WAIT_HIGH;
            end
            HS_WAIT_HIGH: begin
                if (tx_ready) begin
                    done      = 1'b1;
                    state_nxt = HS_IDLE;
                end
            end
            default: state_nxt = HS_IDLE;
        endcase
    end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: decodes host command bytes, gates data_logging for a
// fixed sample count and streams buffered 16-bit samples out high byte first.
// Define CAPTURE_SEQ_HEADER_EN to prefix each dump with sync bytes A5 5A.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int SAMPLE_COUNT = 1024,
    parameter int CNT_W        = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       tx_ready,
    input  logic       sample_valid,
    input  logic       buf_empty,
    output logic       data_logging,
    output logic       buf_rd,
    output logic       txing,
    output logic [1:0] word_to_send_sel,
    output logic       tx_send,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(SAMPLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef CAPTURE_SEQ_HEADER_EN
    localparam state_t FIRST_SEND = HDR0;
`else
    localparam state_t FIRST_SEND = SEND_HI;
`endif

    state_t           state, state_nxt;
    state_t           after_tx, after_tx_nxt;
    logic [CNT_W-1:0] sample_cnt, sample_cnt_nxt;
    logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
    logic             abort_pending, abort_pending_nxt;
    logic             abort_hit, abort_seen;
    logic             hs_go, hs_done;
    logic             data_logging_q, txing_q;
    logic [1:0]       sel_q;

    assign abort_hit  = rx_ready && (rx_data == CMD_ABORT);
    assign abort_seen = abort_pending || abort_hit;

    tx_byte_handshake u_tx_hs (
        .clk      (clk),
        .reset    (reset),
        .go       (hs_go),
        .tx_ready (tx_ready),
        .tx_send  (tx_send),
        .done     (hs_done)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            after_tx       <= IDLE;
            sample_cnt     <= '0;
            word_cnt       <= '0;
            abort_pending  <= 1'b0;
            data_logging_q <= 1'b0;
            txing_q        <= 1'b0;
            sel_q          <= SEL_LO;
        end else begin
            state          <= state_nxt;
            after_tx       <= after_tx_nxt;
            sample_cnt     <= sample_cnt_nxt;
            word_cnt       <= word_cnt_nxt;
            abort_pending  <= abort_pending_nxt;
            data_logging_q <= (state_nxt == LOG);
            if (state_nxt == IDLE) txing_q <= 1'b0;
            else if (tx_send)      txing_q <= 1'b1;
            // Select is loaded on entry to a send state and held until the next.
            if (is_send_state(state_nxt)) sel_q <= sel_for(state_nxt);
        end
    end

    // Next-state, counter updates and strobes.
    always_comb begin
        state_nxt         = state;
        after_tx_nxt      = after_tx;
        sample_cnt_nxt    = sample_cnt;
        word_cnt_nxt      = word_cnt;
        abort_pending_nxt = abort_pending || abort_hit;
        hs_go             = 1'b0;
        buf_rd            = 1'b0;

        case (state)
            IDLE: begin
                abort_pending_nxt = 1'b0;
                if (rx_ready && rx_data == CMD_START) begin
                    state_nxt      = LOG;
                    sample_cnt_nxt = '0;
                end else if (rx_ready && rx_data == CMD_DUMP) begin
                    state_nxt    = FIRST_SEND;
                    word_cnt_nxt = '0;
                end
            end

            LOG: begin
                abort_pending_nxt = 1'b0;
                // A final-count sample still counts even if an abort coincides.
                if (sample_valid) begin
                    sample_cnt_nxt = sample_cnt + CNT_ONE;
                    if (sample_cnt_nxt == LAST) state_nxt = IDLE;
                end
                if (abort_hit) state_nxt = IDLE;
            end

`ifdef CAPTURE_SEQ_HEADER_EN
            HDR0, HDR1,
`endif
            SEND_HI, SEND_LO: begin
                if (abort_seen) begin
                    state_nxt = IDLE;
                end else if (state == SEND_HI && buf_empty) begin
                    state_nxt = IDLE;
                end else begin
                    hs_go = 1'b1;
                    if (tx_send) begin
                        state_nxt    = WAIT_TX;
                        after_tx_nxt = after_byte(state);
                    end
                end
            end

            WAIT_TX: begin
                // A completed low byte finishes the word, so it still advances.
                if (hs_done) begin
                    if (abort_seen && after_tx != ADV) state_nxt = IDLE;
                    else                               state_nxt = after_tx;
                end
            end

            ADV: begin
                buf_rd       = 1'b1;
                word_cnt_nxt = word_cnt + CNT_ONE;
                if (word_cnt_nxt == LAST || buf_empty || abort_seen) state_nxt = IDLE;
                else                                                 state_nxt = SEND_HI;
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign data_logging     = data_logging_q;
    assign txing            = txing_q;
    assign word_to_send_sel = sel_q;
    assign busy             = (state != IDLE);

endmodule
